// File: rtl/rep_pol_pkg.sv
// Shared types, defaults and width helper for the timestamp-LRU replacement policy.
package rep_pol_pkg;

  localparam int DEF_WAYS = 4;
  localparam int DEF_SETS = 16;
  localparam int DEF_TS_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  // Index width that never collapses to zero bits for a single-entry dimension.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rep_pol_ts_ram.sv
// Timestamp array: one write port, one combinational read port, and a
// synchronous whole-array clear used when the global counter wraps.
module rep_pol_ts_ram
  import rep_pol_pkg::*;
#(
  parameter  int WAYS  = DEF_WAYS,
  parameter  int SETS  = DEF_SETS,
  parameter  int TS_W  = DEF_TS_W,
  localparam int SET_W = idx_w(SETS),
  localparam int WAY_W = idx_w(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             clr,
  input  logic [SET_W-1:0] wr_set,
  input  logic [WAY_W-1:0] wr_way,
  input  logic [TS_W-1:0]  wr_data,
  input  logic [SET_W-1:0] rd_set,
  input  logic [WAY_W-1:0] rd_way,
  output logic [TS_W-1:0]  rd_data
);

  logic [TS_W-1:0] mem [SETS][WAYS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is built from flops and must read as all-zero after
      // reset, so it is reset explicitly; a RAM macro could not do this.
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          mem[s][w] <= '0;
        end
      end
    end else begin
      if (clr) begin
        for (int s = 0; s < SETS; s++) begin
          for (int w = 0; w < WAYS; w++) begin
            mem[s][w] <= '0;
          end
        end
      end
      // Placed after the clear so a wrap access still lands its own stamp.
      if (we) begin
        mem[wr_set][wr_way] <= wr_data;
      end
    end
  end

  assign rd_data = mem[rd_set][rd_way];

endmodule

// File: rtl/rep_pol_lru.sv
// Sequential timestamp-LRU victim selector with access and victim-query handshakes.
// Optional invalid-way-first selection is enabled by defining REP_POL_INVALID_FIRST_EN.
module rep_pol_lru
  import rep_pol_pkg::*;
#(
  parameter  int WAYS  = DEF_WAYS,
  parameter  int SETS  = DEF_SETS,
  parameter  int TS_W  = DEF_TS_W,
  localparam int SET_W = idx_w(SETS),
  localparam int WAY_W = idx_w(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc_valid,
  output logic             acc_ready,
  input  logic [SET_W-1:0] acc_set,
  input  logic [WAY_W-1:0] acc_way,
  input  logic             vic_req,
  output logic             vic_ready,
  input  logic [SET_W-1:0] vic_set,
  output logic             vic_valid,
  output logic [WAY_W-1:0] vic_way
);

  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

  state_t           state;
  logic [SET_W-1:0] scan_set;
  logic [WAY_W-1:0] idx;
  logic [WAY_W-1:0] min_way;
  logic [TS_W-1:0]  min_ts;
  logic [TS_W-1:0]  now;
  logic [TS_W-1:0]  rd_ts;
  logic             now_max;
  logic             acc_fire;
  logic             wrap;
  logic             better;

  assign now_max = (now == '1);
  // Hold off accesses that would disturb the set under scan, including a wrap
  // that would clear it.
  assign acc_ready = !((state == SCAN) && ((acc_set == scan_set) || now_max));
  assign vic_ready = (state == IDLE);
  assign acc_fire  = acc_valid && acc_ready;
  assign wrap      = acc_fire && now_max;

  rep_pol_ts_ram #(
    .WAYS (WAYS),
    .SETS (SETS),
    .TS_W (TS_W)
  ) u_ts_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (acc_fire),
    .clr     (wrap),
    .wr_set  (acc_set),
    .wr_way  (acc_way),
    .wr_data (wrap ? TS_W'(1) : now),
    .rd_set  (scan_set),
    .rd_way  (idx),
    .rd_data (rd_ts)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      now <= TS_W'(1);
    end else if (acc_fire) begin
      now <= now_max ? TS_W'(2) : now + TS_W'(1);
    end
  end

`ifdef REP_POL_INVALID_FIRST_EN
  logic [WAYS-1:0] valid [SETS];
  logic            rd_inv;
  logic            min_inv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
      end
    end else if (acc_fire) begin
      valid[acc_set][acc_way] <= 1'b1;
    end
  end

  assign rd_inv = !valid[scan_set][idx];
  // Any invalid way beats every valid way; the first invalid way found is kept.
  assign better = rd_inv ? !min_inv : (!min_inv && (rd_ts < min_ts));
`else
  // Strict compare keeps the lowest index among equal timestamps.
  assign better = (rd_ts < min_ts);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      scan_set  <= '0;
      idx       <= '0;
      min_ts    <= '1;
      min_way   <= '0;
      vic_valid <= 1'b0;
      vic_way   <= '0;
`ifdef REP_POL_INVALID_FIRST_EN
      min_inv   <= 1'b0;
`endif
    end else begin
      // NOTE: every register here uses non-blocking assignment so the
      // compare below sees this cycle's min values, not ones updated mid-block.
      case (state)
        IDLE: begin
          if (vic_req) begin
            scan_set <= vic_set;
            idx      <= '0;
            min_ts   <= '1;
            min_way  <= '0;
`ifdef REP_POL_INVALID_FIRST_EN
            min_inv  <= 1'b0;
`endif
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (better) begin
            min_ts  <= rd_ts;
            min_way <= idx;
`ifdef REP_POL_INVALID_FIRST_EN
            min_inv <= rd_inv;
`endif
          end
          if (idx == LAST_WAY) begin
            // Fold in the final compare so the result is ready in DONE.
            vic_way   <= better ? idx : min_way;
            vic_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + WAY_W'(1);
          end
        end
        DONE: begin
          vic_valid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          vic_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rep_pol_lru.sv
// Directed bench for rep_pol_lru: queries push expected victims into a
// scoreboard that an independent monitor drains whenever vic_valid pulses.
module tb_rep_pol_lru;

  localparam int WAYS = 4;
  localparam int SETS = 16;
  localparam int TS_W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       acc_valid = 1'b0;
  logic       acc_ready;
  logic [3:0] acc_set = '0;
  logic [1:0] acc_way = '0;
  logic       vic_req = 1'b0;
  logic       vic_ready;
  logic [3:0] vic_set = '0;
  logic       vic_valid;
  logic [1:0] vic_way;

  typedef struct {
    int way;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  rep_pol_lru #(
    .WAYS (WAYS),
    .SETS (SETS),
    .TS_W (TS_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .acc_set   (acc_set),
    .acc_way   (acc_way),
    .vic_req   (vic_req),
    .vic_ready (vic_ready),
    .vic_set   (vic_set),
    .vic_valid (vic_valid),
    .vic_way   (vic_way)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every result pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (vic_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("vic_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("vic_way", int'(vic_way), e.way);
        check("vic_latency", cyc, e.cyc);
      end
    end
  end

  task automatic do_reset();
    rst_n     = 1'b0;
    acc_valid = 1'b0;
    vic_req   = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One access cycle; checks the handshake response seen during that cycle.
  task automatic acc(input int s, input int w, input int exp_rdy);
    acc_valid = 1'b1;
    acc_set   = 4'(s);
    acc_way   = 2'(w);
    #1;
    check($sformatf("acc_ready_s%0d_w%0d", s, w), int'(acc_ready), exp_rdy);
    @(posedge clk); #1;
    acc_valid = 1'b0;
  endtask

  task automatic wait_done();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 30) begin
      @(posedge clk); #1;
      budget++;
    end
    if (exp_q.size() != 0) begin
      check("vic_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic query(input int s, input int w);
    check("vic_ready", int'(vic_ready), 1);
    vic_req = 1'b1;
    vic_set = 4'(s);
    exp_q.push_back('{way: w, cyc: cyc + WAYS + 1});
    @(posedge clk); #1;
    vic_req = 1'b0;
    wait_done();
    check("vic_way_hold", int'(vic_way), w);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_vic_valid", int'(vic_valid), 0);
    check("rst_vic_way", int'(vic_way), 0);
    check("rst_vic_ready", int'(vic_ready), 1);
    check("rst_acc_ready", int'(acc_ready), 1);
    @(posedge clk); #1;

    // All timestamps zero: tie resolves to way 0.
    query(0, 0);

    // Way 0 re-stamped newest, so way 1 becomes oldest.
    do_reset();
    acc(2, 0, 1); acc(2, 1, 1); acc(2, 2, 1); acc(2, 3, 1); acc(2, 0, 1);
    query(2, 1);

    // Set 3 ts = 3,5,8,2 with fillers on set 0.
    do_reset();
    acc(0, 0, 1); acc(3, 3, 1); acc(3, 0, 1); acc(0, 1, 1);
    acc(3, 1, 1); acc(0, 2, 1); acc(0, 3, 1); acc(3, 2, 1);
    query(3, 3);
    acc(3, 0, 1);            // ts 9,5,8,2
    query(3, 3);
    acc(3, 3, 1);            // ts 9,5,8,10
    query(3, 1);
    acc(10, 0, 1); acc(10, 3, 1);   // ways 1 and 2 tie at 0
    query(10, 1);

    // Access and query on the same set in the same cycle: scan sees the access.
    do_reset();
    acc(4, 1, 1); acc(4, 2, 1); acc(4, 3, 1);
    vic_req = 1'b1;
    vic_set = 4'd4;
    exp_q.push_back('{way: 1, cyc: cyc + WAYS + 1});
    acc(4, 0, 1);
    vic_req = 1'b0;
    wait_done();

    // Scan on set 5 blocks set-5 accesses until DONE; set 6 proceeds.
    do_reset();
    acc(5, 0, 1); acc(5, 2, 1); acc(5, 3, 1);
    acc(6, 0, 1); acc(6, 1, 1); acc(6, 3, 1);
    vic_req = 1'b1;
    vic_set = 4'd5;
    exp_q.push_back('{way: 1, cyc: cyc + WAYS + 1});
    @(posedge clk); #1;
    vic_req = 1'b0;
    acc(5, 1, 0);            // cycle 1
    acc(5, 1, 0);            // cycle 2
    acc(6, 2, 1);            // cycle 3
    acc(5, 1, 0);            // cycle 4
    acc(5, 1, 1);            // cycle 5, DONE
    wait_done();
    query(5, 0);             // ts 1,8,2,3
    query(6, 0);             // ts 4,5,7,6

    // Counter wrap on the 255th access clears the array.
    do_reset();
    for (int i = 0; i < 254; i++) acc(7, i % 4, 1);
    acc(8, 2, 1);            // wraps: set 8 way 2 = 1, now = 2
    query(7, 0);
    query(8, 0);
    acc(8, 0, 1); acc(8, 1, 1);     // ts 2,3,1,0
    query(8, 3);
    acc(8, 3, 1);            // ts 2,3,1,4
    query(8, 2);
    acc(8, 2, 1);            // ts 2,3,5,4
    query(8, 0);

    // Never-accessed way is chosen; then plain LRU once all are stamped.
    do_reset();
    acc(1, 0, 1); acc(1, 1, 1); acc(1, 3, 1);
    query(1, 2);
    acc(1, 2, 1);
    query(1, 0);

    // Reset mid-scan: back to IDLE at once, no result pulse.
    vic_req = 1'b1;
    vic_set = 4'd1;
    @(posedge clk); #1;
    vic_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midscan_vic_ready", int'(vic_ready), 1);
    check("midscan_vic_valid", int'(vic_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    query(1, 0);             // state cleared: all ts 0

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/rep_pol_lru.md
# rep_pol_lru

Sequential, parametrised timestamp-LRU replacement policy for a set-associative cache. It holds one timestamp per way per set, stamps a way on every access, and on request scans a set to return the way with the lowest (oldest) timestamp. It sits beside the tag array in the cache controller and generalises the fixed 4-line combinational victim selector to any power-of-two associativity and set count, with a request/response handshake.

## Interface
- WAYS, 4: associativity; power of two, >= 2.
- SETS, 16: number of sets; power of two.
- TS_W, 8: timestamp width; >= 2.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- acc_valid  in  1  access (hit or fill) to stamp.
- acc_ready  out  1  access accepted when acc_valid && acc_ready.
- acc_set  in  $clog2(SETS)  set of access.
- acc_way  in  $clog2(WAYS)  way of access.
- vic_req  in  1  victim query request.
- vic_ready  out  1  high in IDLE only.
- vic_set  in  $clog2(SETS)  set to scan; sampled on accept.
- vic_valid  out  1  one-cycle pulse, result valid.
- vic_way  out  $clog2(WAYS)  victim way; held until next result.

## Operation
- Storage: ts[SETS][WAYS] of TS_W bits; global counter now of TS_W bits.
- Access accept: ts[acc_set][acc_way] <= now; now <= now + 1.
- Wrap: access accepted with now == 2^TS_W-1 clears every ts entry to 0, writes 1 into the accessed entry, sets now <= 2. Relative order of other ways is lost; documented, not an error.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: vic_ready=1; vic_req accepted -> latch set, idx=0, min=all-ones, min_way=0 -> SCAN.
  - SCAN: compare ts[set][idx] against min using strict less-than; on true update min, min_way. idx == WAYS-1 -> DONE, else idx+1.
  - DONE: vic_valid=1, vic_way=min_way -> IDLE.
- Ties: strictly-less compare means lowest index wins among equal timestamps.
- Scan reads the live array. acc_ready=0 while FSM is SCAN and (acc_set == latched set, or now == 2^TS_W-1); otherwise acc_ready=1. This keeps the set under scan stable.
- Accesses to other sets proceed during a scan.
- Victim query does not stamp the returned way; the caller's fill access does that.

## Timing
- Reset values:
  - ts all 0; now = 1; state IDLE.
  - vic_valid = 0; vic_way = 0; vic_ready = 1; acc_ready = 1.
  - Valid bits all 0 when the macro is enabled.
- Access write is visible to a scan from the next cycle.
- Victim latency: accept in cycle 0, compares in cycles 1..WAYS, vic_valid in cycle WAYS+1.
- Next request can be accepted in cycle WAYS+2.
- Same-cycle access and request on the same set: the access is applied first; the scan observes it.
- Reset asserted mid-scan: FSM returns to IDLE immediately, no vic_valid is produced, and all state clears.

## Configuration
- REP_POL_INVALID_FIRST_EN defined:
  - Adds valid[SETS][WAYS]; an accepted access sets valid for its way.
  - During SCAN, an invalid way beats any valid way.
  - Among invalid ways, the lowest index wins.
  - Latency is unchanged.
- Undefined: no valid bits; pure timestamp LRU, where never-accessed ways (ts=0) naturally lose first.

## Structure
- Package rep_pol_pkg:
  - state enum (IDLE, SCAN, DONE).
  - Default WAYS/SETS/TS_W constants.
  - Derived index-width helper.
- One sub-module: rep_pol_ts_ram, the timestamp array with one write port and one combinational read port, plus synchronous global clear for wrap.

## Test plan
- Reset, then query set 0 -> after 5 cycles vic_valid=1, vic_way=0 (all ts 0, tie to lowest).
- Set 2, access ways 0,1,2,3 -> ts=1,2,3,4; access way 0 again (ts=5); query set 2 -> vic_way=1.
- Set 3, with ts=3,5,8,2 -> vic_way=3. Set way 3 to 3 -> vic_way=0 (tie, lowest index). Re-stamp way 0 newest -> vic_way=3. Re-stamp way 3 newest -> vic_way=1.
- TS_W=4, run 15 accesses to force the wrap -> all entries clear, accessed way=1, now=2; next query on another set returns way 0.
- Scan in progress on set 5: acc_valid to set 5 -> acc_ready=0 until DONE; access to set 6 in the same cycle -> accepted.
- With REP_POL_INVALID_FIRST_EN: stamp ways 0,1,3 of set 1 -> vic_way=2. Without the macro, the same stimulus -> vic_way=2 via ts=0. After stamping way 2 -> vic_way=0.
